md_issue_ctrl: RTL and testbench

//  E-stage issue/stall controller sitting directly upstream of the MD (mult/div) unit.

---
 rtl/md_pkg.sv | 73 +++++++
 rtl/md_issue_ctrl.sv | 132 +++++++++++++
 tb/tb_md_issue_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg
//   Shared definitions for the MD (mult/div) issue path.
//
//   This package holds:
//     - MDC_*        4-bit MD-class op codes carried down the pipeline.
//     - MD_OP_*      3-bit op codes understood by the MD unit.
//     - E_MF_SEL_*   E-stage result mux selects.
//     - md_state_t   issue-controller FSM states.
//     - md_dec_t     decoded view of an MD-class op.
//     - md_decode()  combinational decode/map from MDC_* to md_dec_t.
// ---------------------------------------------------------------------------
package md_pkg;

    localparam logic [3:0] MDC_NONE  = 4'd0;
    localparam logic [3:0] MDC_MULT  = 4'd1;
    localparam logic [3:0] MDC_MULTU = 4'd2;
    localparam logic [3:0] MDC_DIV   = 4'd3;
    localparam logic [3:0] MDC_DIVU  = 4'd4;
    localparam logic [3:0] MDC_MTHI  = 4'd5;
    localparam logic [3:0] MDC_MTLO  = 4'd6;
    localparam logic [3:0] MDC_MFHI  = 4'd7;
    localparam logic [3:0] MDC_MFLO  = 4'd8;

    localparam logic [2:0] MD_OP_MULTU = 3'b000;
    localparam logic [2:0] MD_OP_MULT  = 3'b001;
    localparam logic [2:0] MD_OP_DIVU  = 3'b010;
    localparam logic [2:0] MD_OP_DIV   = 3'b011;

    localparam logic [1:0] E_MF_SEL_ALU = 2'b00;
    localparam logic [1:0] E_MF_SEL_HI  = 2'b01;
    localparam logic [1:0] E_MF_SEL_LO  = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    typedef struct packed {
        logic       is_issue;   // mult/multu/div/divu: starts the MD unit
        logic       is_div;     // selects the div latency for the busy counter
        logic [2:0] md_op;      // MD unit op code (MULTU when not issuing)
        logic       is_mthi;
        logic       is_mtlo;
        logic [1:0] mf_sel;     // E result mux select for mfhi/mflo
    } md_dec_t;

    // Codes 9..15 fall into the default arm and decode exactly like MDC_NONE.
    function automatic md_dec_t md_decode(input logic [3:0] op);
        md_dec_t d;
        d          = '0;
        d.md_op    = MD_OP_MULTU;
        d.mf_sel   = E_MF_SEL_ALU;
        case (op)
            MDC_MULT:  begin d.is_issue = 1'b1; d.md_op = MD_OP_MULT;  end
            MDC_MULTU: begin d.is_issue = 1'b1; d.md_op = MD_OP_MULTU; end
            MDC_DIV:   begin d.is_issue = 1'b1; d.is_div = 1'b1; d.md_op = MD_OP_DIV;  end
            MDC_DIVU:  begin d.is_issue = 1'b1; d.is_div = 1'b1; d.md_op = MD_OP_DIVU; end
            MDC_MTHI:  d.is_mthi = 1'b1;
            MDC_MTLO:  d.is_mtlo = 1'b1;
            MDC_MFHI:  d.mf_sel  = E_MF_SEL_HI;
            MDC_MFLO:  d.mf_sel  = E_MF_SEL_LO;
            default:   ;
        endcase
        return d;
    endfunction

    // True for any real MD-class op (1..8); 0 and 9..15 are not MD-class.
    function automatic logic md_is_md_class(input logic [3:0] op);
        return (op >= MDC_MULT) && (op <= MDC_MFLO);
    endfunction

endpackage

// File: rtl/md_issue_ctrl.sv
// ---------------------------------------------------------------------------
// md_issue_ctrl
//   E-stage issue/stall controller in front of the MD (mult/div) unit.
//   Decodes the MD-class op in E, drives the MD start/op/HI/LO write strobes
//   and operands, mirrors the MD busy window with a private latency counter,
//   stalls D while an MD-class instruction there must wait, selects the
//   HI/LO read for mfhi/mflo, and flags any disagreement with md_busy.
//
//   Parameters
//     MULT_CYCLES  busy cycles after a mult/multu start edge (= MD mult latency)
//     DIV_CYCLES   busy cycles after a div/divu start edge  (= MD div latency)
//     CNT_W        counter width, 2**CNT_W > max(MULT_CYCLES, DIV_CYCLES)
//
//   Ports
//     clk, reset          posedge clock, asynchronous active-high reset
//     d_md_op[3:0]        MD-class op of the instruction in D
//     e_md_op[3:0]        MD-class op of the instruction in E
//     e_valid, e_flush    E slot holds a real instruction / is killed
//     e_rs, e_rt[31:0]    forwarded operands in E
//     md_busy             busy flag from the MD unit
//     md_start            MD start strobe (combinational)
//     md_op[2:0]          MD op code, 000 when not issuing
//     md_hi_write/lo      mthi / mtlo strobes
//     md_a, md_b[31:0]    MD operands (e_rs / e_rt)
//     e_mf_sel[1:0]       E result mux: 00 ALU, 01 HI, 10 LO
//     stall_d             freeze PC and IF/ID, bubble into ID/EX
//     md_err              sticky tracker/issue consistency error
// ---------------------------------------------------------------------------
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  d_md_op,
    input  logic [3:0]  e_md_op,
    input  logic        e_valid,
    input  logic        e_flush,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        md_busy,
    output logic        md_start,
    output logic [2:0]  md_op,
    output logic        md_hi_write,
    output logic        md_lo_write,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic [1:0]  e_mf_sel,
    output logic        stall_d,
    output logic        md_err
);

    md_state_t          r_state;
    md_state_t          w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_err;

    md_dec_t            w_dec;
    logic               w_live;
    logic               w_issue_req;
    logic               w_idle;
    logic               w_busy_i;
    logic               w_err_set;

    assign w_dec       = md_decode(e_md_op);
    assign w_live      = e_valid & ~e_flush;
    assign w_issue_req = w_live & w_dec.is_issue;
    assign w_idle      = (r_state == ST_IDLE);
    assign w_busy_i    = (r_state == ST_RUN);

    // E-stage MD strobes: nothing may be started or written while MD is busy.
    assign md_start    = w_issue_req & w_idle;
    assign md_op       = md_start ? w_dec.md_op : MD_OP_MULTU;
    assign md_hi_write = w_live & w_dec.is_mthi & w_idle;
    assign md_lo_write = w_live & w_dec.is_mtlo & w_idle;
    assign md_a        = e_rs;
    assign md_b        = e_rt;
    assign e_mf_sel    = e_valid ? w_dec.mf_sel : E_MF_SEL_ALU;

    // The issue cycle itself stalls D too, so the stall spans 1 + latency cycles.
    assign stall_d     = md_is_md_class(d_md_op) & (md_start | w_busy_i);

    // md_busy rises one edge after start, the same edge our FSM enters RUN,
    // so a straight per-cycle comparison needs no skew compensation.
    assign w_err_set   = (w_busy_i != md_busy) | (w_issue_req & w_busy_i);
    assign md_err      = r_err;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (md_start) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = w_dec.is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end
            end
            ST_RUN: begin
                // A flush in E cannot cancel MD, so RUN always drains to zero.
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
module tb_md_issue_ctrl;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  d_md_op;
    logic [3:0]  e_md_op;
    logic        e_valid;
    logic        e_flush;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        md_busy;
    logic        md_start;
    logic [2:0]  md_op;
    logic        md_hi_write;
    logic        md_lo_write;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic [1:0]  e_mf_sel;
    logic        stall_d;
    logic        md_err;

    int total = 0;
    int bad   = 0;

    md_issue_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .d_md_op(d_md_op), .e_md_op(e_md_op),
        .e_valid(e_valid), .e_flush(e_flush), .e_rs(e_rs), .e_rt(e_rt),
        .md_busy(md_busy), .md_start(md_start), .md_op(md_op),
        .md_hi_write(md_hi_write), .md_lo_write(md_lo_write),
        .md_a(md_a), .md_b(md_b), .e_mf_sel(e_mf_sel),
        .stall_d(stall_d), .md_err(md_err)
    );

    always #5 clk = ~clk;

    // Behavioural MD unit: synchronous reset, latency 5 (mult) / 10 (div),
    // results written into HI/LO at the start edge.
    int          m_cnt = 0;
    logic [31:0] m_hi  = '0;
    logic [31:0] m_lo  = '0;
    logic        force_low = 1'b0;
    logic [63:0] m_prod;

    assign md_busy = (m_cnt != 0) & ~force_low;

    always @(posedge clk) begin
        if (reset) begin
            m_cnt <= 0;
        end else if (md_start) begin
            case (md_op)
                3'b000: begin m_prod = {32'd0, md_a} * {32'd0, md_b}; m_hi <= m_prod[63:32]; m_lo <= m_prod[31:0]; m_cnt <= 5; end
                3'b001: begin m_prod = $signed({{32{md_a[31]}}, md_a}) * $signed({{32{md_b[31]}}, md_b});
                              m_hi <= m_prod[63:32]; m_lo <= m_prod[31:0]; m_cnt <= 5; end
                3'b010: begin if (md_b != 0) begin m_lo <= md_a / md_b; m_hi <= md_a % md_b; end m_cnt <= 10; end
                default: begin if (md_b != 0) begin m_lo <= $signed(md_a) / $signed(md_b); m_hi <= $signed(md_a) % $signed(md_b); end m_cnt <= 10; end
            endcase
        end else begin
            if (m_cnt != 0) m_cnt <= m_cnt - 1;
            if (md_hi_write) m_hi <= md_a;
            if (md_lo_write) m_lo <= md_a;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic [3:0] d, input logic [3:0] e, input logic v, input logic f,
                       input logic [31:0] rs, input logic [31:0] rt);
        d_md_op = d; e_md_op = e; e_valid = v; e_flush = f; e_rs = rs; e_rt = rt;
    endtask

    // Keep E empty and D at op d; return how many further cycles stall_d stays high.
    task automatic count_stall(input logic [3:0] d, output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drv(d, MDC_NONE, 1'b0, 1'b0, 32'd0, 32'd0);
            #1;
            if (!stall_d) break;
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        drv(MDC_MFHI, MDC_NONE, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk); @(negedge clk);
        #1;
        check("rst_err", md_err, 0);
        check("rst_stall", stall_d, 0);
        check("rst_start", md_start, 0);
        reset = 1'b0;

        // 1: mult 7 * -3 with mfhi waiting in D
        @(negedge clk);
        drv(MDC_MFHI, MDC_MULT, 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        #1;
        check("t1_start", md_start, 1);
        check("t1_op", md_op, 3'b001);
        check("t1_a", md_a, 32'd7);
        check("t1_b", md_b, 32'hFFFF_FFFD);
        check("t1_stall0", stall_d, 1);
        count_stall(MDC_MFHI, n);
        check("t1_stall_len", n + 1, 6);
        @(negedge clk);
        drv(MDC_NONE, MDC_MFHI, 1'b1, 1'b0, 32'd0, 32'd0);
        #1;
        check("t1_mfsel", e_mf_sel, 2'b01);
        check("t1_hi", m_hi, 32'hFFFF_FFFF);
        check("t1_lo", m_lo, 32'hFFFF_FFEB);
        check("t1_err", md_err, 0);

        // 2: divu 100 / 7 with mflo waiting in D
        @(negedge clk);
        drv(MDC_MFLO, MDC_DIVU, 1'b1, 1'b0, 32'd100, 32'd7);
        #1;
        check("t2_op", md_op, 3'b010);
        check("t2_stall0", stall_d, 1);
        count_stall(MDC_MFLO, n);
        check("t2_stall_len", n + 1, 11);
        @(negedge clk);
        drv(MDC_NONE, MDC_MFLO, 1'b1, 1'b0, 32'd0, 32'd0);
        #1;
        check("t2_mfsel", e_mf_sel, 2'b10);
        check("t2_lo", m_lo, 32'd14);
        check("t2_hi", m_hi, 32'd2);

        // 3: mult in E, non-MD (addu, then reserved code 9) in D never stalls
        @(negedge clk);
        drv(MDC_NONE, MDC_MULTU, 1'b1, 1'b0, 32'd3, 32'd4);
        #1;
        check("t3_start", md_start, 1);
        check("t3_stall0", stall_d, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drv(4'd9, MDC_NONE, 1'b0, 1'b0, 32'd0, 32'd0);
            #1;
            check("t3_stall", stall_d, 0);
        end
        check("t3_err", md_err, 0);
        check("t3_busy_done", md_busy, 0);

        // 4: flushed div does not start; mthi next cycle writes HI
        @(negedge clk);
        drv(MDC_MFLO, MDC_DIV, 1'b1, 1'b1, 32'd50, 32'd5);
        #1;
        check("t4_start", md_start, 0);
        check("t4_stall", stall_d, 0);
        @(negedge clk);
        drv(MDC_MFLO, MDC_MTHI, 1'b1, 1'b0, 32'h1234, 32'd0);
        #1;
        check("t4_stall_idle", stall_d, 0);
        check("t4_hiw", md_hi_write, 1);
        check("t4_low", md_lo_write, 0);
        @(negedge clk);
        drv(MDC_NONE, MDC_NONE, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check("t4_hi", m_hi, 32'h1234);
        check("t4_err", md_err, 0);

        // 5: reset two cycles into a mult, then a fresh multu issues
        @(negedge clk);
        drv(MDC_NONE, MDC_MULT, 1'b1, 1'b0, 32'd2, 32'd2);
        @(negedge clk);
        drv(MDC_MFHI, MDC_NONE, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check("t5_stall_run", stall_d, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t5_rst_stall", stall_d, 0);
        check("t5_rst_err", md_err, 0);
        @(negedge clk);
        reset = 1'b0;
        drv(MDC_MFLO, MDC_MULTU, 1'b1, 1'b0, 32'd6, 32'd7);
        #1;
        check("t5_start", md_start, 1);
        check("t5_op", md_op, 3'b000);
        count_stall(MDC_MFLO, n);
        check("t5_stall_len", n + 1, 6);
        check("t5_lo", m_lo, 32'd42);
        check("t5_err", md_err, 0);

        // 6: md_busy forced low during RUN sets sticky error
        @(negedge clk);
        drv(MDC_NONE, MDC_MULT, 1'b1, 1'b0, 32'd1, 32'd1);
        @(negedge clk);
        drv(MDC_NONE, MDC_NONE, 1'b0, 1'b0, 32'd0, 32'd0);
        force_low = 1'b1;
        #1;
        check("t6_err_pre", md_err, 0);
        @(negedge clk);
        force_low = 1'b0;
        #1;
        check("t6_err_set", md_err, 1);
        for (int i = 0; i < 6; i++) @(negedge clk);
        #1;
        check("t6_err_sticky", md_err, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t6_err_clr", md_err, 0);

        // Issue-class op and mthi presented while RUN: blocked, error flagged
        @(negedge clk);
        drv(MDC_NONE, MDC_DIV, 1'b1, 1'b0, 32'd9, 32'd3);
        @(negedge clk);
        drv(MDC_MFHI, MDC_MULT, 1'b1, 1'b0, 32'd5, 32'd5);
        #1;
        check("t7_start", md_start, 0);
        check("t7_op", md_op, 3'b000);
        check("t7_stall", stall_d, 1);
        @(negedge clk);
        drv(MDC_NONE, MDC_MTHI, 1'b1, 1'b0, 32'hABCD, 32'd0);
        #1;
        check("t7_hiw", md_hi_write, 0);
        check("t7_err", md_err, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drv(MDC_NONE, MDC_NONE, 1'b0, 1'b0, 32'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
